// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and defaults for the HPS-to-SDRAM ROM download bridge
package rom_dl_pkg;

  localparam int ROM_DL_FIFO_DEPTH   = 4;
  localparam int ROM_DL_ADDR_W       = 21;
  // Entry address field is sized for the widest word address a 25-bit byte address can carry.
  localparam int ROM_DL_ENTRY_ADDR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } rom_dl_state_t;

  typedef struct packed {
    logic [ROM_DL_ENTRY_ADDR_W-1:0] addr;
    logic [15:0]                    data;
  } rom_dl_entry_t;

  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/rom_dl_fifo.sv
// rtl/rom_dl_fifo.sv - register FIFO of pending ROM write entries
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter  int DEPTH = ROM_DL_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  rom_dl_entry_t    push_entry,
  input  logic             pop,
  output rom_dl_entry_t    head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  rom_dl_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/rom_dl_bridge.sv
// rtl/rom_dl_bridge.sv - buffers HPS download words and issues toggle-handshake SDRAM ROM writes
// Define ROM_CHECKSUM_EN to add the checksum output over acknowledged words.
module rom_dl_bridge
  import rom_dl_pkg::*;
#(
  parameter int FIFO_DEPTH = ROM_DL_FIFO_DEPTH,
  parameter int ADDR_W     = ROM_DL_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [15:0]       dl_data,
  output logic              dl_wait,
  output logic              rom_req,
  input  logic              rom_ack,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              dl_done,
  output logic [ADDR_W-1:0] words_written,
  output logic              overflow
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rom_dl_state_t    state;
  rom_dl_entry_t    push_entry;
  rom_dl_entry_t    head;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_ok;
  logic             pop;
  logic             ack_match;
  logic             dl_active_q;
  logic             active_rise;
  logic             active_fall;
  logic             done_armed;
  logic             done_cond;
  logic             unused_addr_bits;

  assign push_entry.addr  = ROM_DL_ENTRY_ADDR_W'(dl_addr[ADDR_W:1]);
  assign push_entry.data  = byte_swap(dl_data);
  assign push_ok          = dl_wr && !fifo_full;
  assign ack_match        = (rom_ack == rom_req);
  assign pop              = (state == ST_WAIT_ACK) && ack_match;
  assign active_rise      = dl_active && !dl_active_q;
  assign active_fall      = !dl_active && dl_active_q;
  assign done_cond        = (done_armed || active_fall) && !dl_active && fifo_empty && (state == ST_IDLE);
  assign unused_addr_bits = ^{dl_addr, head.addr};

  rom_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .push       (dl_wr),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    count_next = fifo_count;
    if (push_ok && !pop)      count_next = fifo_count + 1'b1;
    else if (!push_ok && pop) count_next = fifo_count - 1'b1;
  end

  // Entry stays at the FIFO head until acknowledged, so rom_addr/rom_data hold for the whole handshake.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rom_req  <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_REQ;
        end
        ST_REQ: begin
          rom_addr <= head.addr[ADDR_W-1:0];
          rom_data <= head.data;
          rom_req  <= ~rom_req;
          state    <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_match) state <= (count_next != '0) ? ST_REQ : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // dl_wait is computed from the next count so the registered flag tracks the current occupancy.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_active_q   <= 1'b0;
      dl_wait       <= 1'b0;
      words_written <= '0;
      overflow      <= 1'b0;
      done_armed    <= 1'b0;
      dl_done       <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      dl_wait     <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
      dl_done     <= done_cond;
      if (active_rise) begin
        words_written <= '0;
        overflow      <= 1'b0;
      end else begin
        if (pop)                 words_written <= words_written + 1'b1;
        if (dl_wr && fifo_full)  overflow      <= 1'b1;
      end
      if (active_rise || done_cond) done_armed <= 1'b0;
      else if (active_fall)         done_armed <= 1'b1;
    end
  end

`ifdef ROM_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)         checksum <= '0;
    else if (active_rise) checksum <= '0;
    else if (pop)         checksum <= checksum + rom_data;
  end
`endif

endmodule

// File: tb/tb_rom_dl_bridge.sv
// tb/tb_rom_dl_bridge.sv - scoreboard bench for rom_dl_bridge; checksum cases need ROM_CHECKSUM_EN
module tb_rom_dl_bridge;

  typedef struct {
    logic [20:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [15:0] dl_data;
  logic        dl_wait;
  logic        rom_req;
  logic        rom_ack;
  logic [20:0] rom_addr;
  logic [15:0] rom_data;
  logic        dl_done;
  logic [20:0] words_written;
  logic        overflow;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  exp_t        sb_q[$];
  exp_t        cur_exp;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_cyc = 0;
  int          toggle_cyc = 0;
  int          toggles = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          ww_cyc = 0;
  int          ack_delay = 1;
  bit          ack_hold = 1'b0;
  logic        last_req = 1'b0;
  bit          pending = 1'b0;
  logic [20:0] prev_ww = '0;

  rom_dl_bridge dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .dl_active     (dl_active),
    .dl_wr         (dl_wr),
    .dl_addr       (dl_addr),
    .dl_data       (dl_data),
    .dl_wait       (dl_wait),
    .rom_req       (rom_req),
    .rom_ack       (rom_ack),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .dl_done       (dl_done),
    .words_written (words_written),
    .overflow      (overflow)
`ifdef ROM_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // SDRAM side: acknowledges an outstanding toggle after ack_delay cycles unless held.
  initial begin
    int cnt = 0;
    rom_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        rom_ack = 1'b0;
        cnt = 0;
      end else if (rom_req != rom_ack && !ack_hold) begin
        cnt++;
        if (cnt >= ack_delay) begin
          rom_ack = rom_req;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every rom_req toggle must match the next scoreboard entry and hold until acked.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        last_req = 1'b0;
        pending = 1'b0;
      end else if (rom_req != last_req) begin
        last_req = rom_req;
        toggles++;
        toggle_cyc = cyc;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req act_addr=%h act_data=%h exp=none", rom_addr, rom_data);
        end else begin
          cur_exp = sb_q.pop_front();
          chk("req_addr", 32'(rom_addr), 32'(cur_exp.addr));
          chk("req_data", 32'(rom_data), 32'(cur_exp.data));
          pending = 1'b1;
        end
      end else if (pending && rom_ack == rom_req) begin
        chk("hold_addr", 32'(rom_addr), 32'(cur_exp.addr));
        chk("hold_data", 32'(rom_data), 32'(cur_exp.data));
        pending = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      if (dl_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (words_written != prev_ww) begin
        prev_ww = words_written;
        ww_cyc = cyc;
      end
    end
  end

  task automatic do_write(input logic [24:0] a, input logic [15:0] d,
                          input logic [20:0] ea, input logic [15:0] ed, input bit acc);
    exp_t e;
    dl_addr = a;
    dl_data = d;
    dl_wr = 1'b1;
    if (acc) begin
      e.addr = ea;
      e.data = ed;
      sb_q.push_back(e);
    end
    @(negedge clk_sys);
    wr_cyc = cyc;
    dl_wr = 1'b0;
  endtask

  task automatic wait_ww(input logic [20:0] target, input int budget, input string name);
    for (int i = 0; i < budget && words_written != target; i++) @(negedge clk_sys);
    chk(name, 32'(words_written), 32'(target));
  endtask

  task automatic new_download();
    dl_active = 1'b0;
    repeat (2) @(negedge clk_sys);
    dl_active = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_req"}, 32'(rom_req), 0);
    chk({tag, "_dl_wait"}, 32'(dl_wait), 0);
    chk({tag, "_dl_done"}, 32'(dl_done), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_ww"}, 32'(words_written), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_rom_data"}, 32'(rom_data), 0);
`ifdef ROM_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(checksum), 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int first_wait;
    int t0;
    reset_n = 1'b0;
    dl_active = 1'b0;
    dl_wr = 1'b0;
    dl_addr = '0;
    dl_data = '0;
    repeat (2) @(negedge clk_sys);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Single write, latency and byte swap
    dl_active = 1'b1;
    repeat (2) @(negedge clk_sys);
    do_write(25'h0000102, 16'h3412, 21'h000081, 16'h1234, 1'b1);
    wait_ww(1, 50, "single_ww");
    chk("single_latency", 32'(toggle_cyc - wr_cyc), 2);

    // Upper address bits ignored
    do_write(25'h1400006, 16'hBEEF, 21'h000003, 16'hEFBE, 1'b1);
    do_write(25'h1FFFFFF, 16'h0001, 21'h1FFFFF, 16'h0100, 1'b1);
    wait_ww(3, 100, "wrap_ww");

    // Burst honouring dl_wait with slow acks
    new_download();
    chk("burst_ww_clear", 32'(words_written), 0);
    ack_delay = 6;
    issued = 0;
    first_wait = -1;
    for (int g = 0; g < 400 && issued < 8; g++) begin
      if (dl_wait) begin
        if (first_wait < 0) first_wait = issued;
        @(negedge clk_sys);
      end else begin
        do_write(25'h0000200 + 25'(2 * issued), {8'hA0 + 8'(issued), 8'h50 + 8'(issued)},
                 21'h000100 + 21'(issued), {8'h50 + 8'(issued), 8'hA0 + 8'(issued)}, 1'b1);
        issued++;
      end
    end
    chk("burst_issued", 32'(issued), 8);
    chk("burst_wait_at3", 32'(first_wait), 3);
    wait_ww(8, 400, "burst_ww");
    chk("burst_overflow", 32'(overflow), 0);

    // Forced overflow with acks stalled
    new_download();
    chk("ovf_ww_clear", 32'(words_written), 0);
    ack_hold = 1'b1;
    ack_delay = 1;
    for (int i = 0; i < 5; i++) begin
      do_write(25'h0000400 + 25'(2 * i), {8'h10 + 8'(i), 8'hC0 + 8'(i)},
               21'h000200 + 21'(i), {8'hC0 + 8'(i), 8'h10 + 8'(i)}, i < 4);
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_dl_wait", 32'(dl_wait), 1);
    ack_hold = 1'b0;
    wait_ww(4, 100, "ovf_ww");
    repeat (5) @(negedge clk_sys);
    chk("ovf_sticky", 32'(overflow), 1);

    // End of download with two entries pending
    new_download();
    done_cnt = 0;
    ack_hold = 1'b1;
    do_write(25'h0000600, 16'h2211, 21'h000300, 16'h1122, 1'b1);
    do_write(25'h0000602, 16'h4433, 21'h000301, 16'h3344, 1'b1);
    dl_active = 1'b0;
    repeat (5) @(negedge clk_sys);
    chk("done_early", 32'(done_cnt), 0);
    ack_delay = 2;
    ack_hold = 1'b0;
    wait_ww(2, 100, "done_ww");
    repeat (10) @(negedge clk_sys);
    chk("done_once", 32'(done_cnt), 1);
    chk("done_timing", 32'(done_cyc - ww_cyc), 1);

    // Reset while waiting for an ack
    ack_delay = 1;
    new_download();
    ack_hold = 1'b1;
    t0 = toggles;
    do_write(25'h0000010, 16'hAA55, 21'h000008, 16'h55AA, 1'b1);
    for (int i = 0; i < 20 && toggles == t0; i++) @(negedge clk_sys);
    chk("rst_req_issued", 32'(toggles - t0), 1);
    reset_n = 1'b0;
    rom_ack = 1'b0;
    sb_q.delete();
    @(negedge clk_sys);
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    ack_hold = 1'b0;
    t0 = toggles;
    repeat (10) @(negedge clk_sys);
    chk("rst_no_req", 32'(toggles - t0), 0);

`ifdef ROM_CHECKSUM_EN
    new_download();
    do_write(25'h0000020, 16'hFFFF, 21'h000010, 16'hFFFF, 1'b1);
    do_write(25'h0000022, 16'h0200, 21'h000011, 16'h0002, 1'b1);
    wait_ww(2, 50, "csum_ww");
    chk("csum_value", 32'(checksum), 32'h0001);
`endif

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
